// File: rtl/tilelink_regfile_pkg.sv
// tilelink_regfile_pkg: TileLink-UL channel types, register kinds and mask helper
package tilelink_regfile_pkg;

    localparam int TL_AW = 32;
    localparam int TL_DW = 32;
    localparam int TL_SW = 3;
    localparam int TL_IW = 8;

    typedef enum logic [2:0] {
        PUT_FULL_DATA    = 3'd0,
        PUT_PARTIAL_DATA = 3'd1,
        ARITHMETIC_DATA  = 3'd2,
        LOGICAL_DATA     = 3'd3,
        GET              = 3'd4,
        HINT             = 3'd5
    } tl_a_op_e;

    typedef enum logic [2:0] {
        ACCESS_ACK      = 3'd0,
        ACCESS_ACK_DATA = 3'd1,
        HINT_ACK        = 3'd2
    } tl_d_op_e;

    typedef struct packed {
        logic               a_valid;
        tl_a_op_e           a_opcode;
        logic [2:0]         a_param;
        logic [TL_SW-1:0]   a_size;
        logic [TL_IW-1:0]   a_source;
        logic [TL_AW-1:0]   a_address;
        logic [TL_DW/8-1:0] a_mask;
        logic [TL_DW-1:0]   a_data;
    } tilelink_a;

    typedef struct packed {
        logic             d_valid;
        tl_d_op_e         d_opcode;
        logic [2:0]       d_param;
        logic [TL_SW-1:0] d_size;
        logic [TL_IW-1:0] d_source;
        logic             d_sink;
        logic [TL_DW-1:0] d_data;
        logic             d_error;
        logic             d_ready;
    } tilelink_d;

    localparam logic [1:0] REG_RW  = 2'd0;
    localparam logic [1:0] REG_RO  = 2'd1;
    localparam logic [1:0] REG_W1C = 2'd2;

    function automatic logic [TL_DW-1:0] expand_bitmask(input logic [TL_DW/8-1:0] m);
        logic [TL_DW-1:0] r;
        for (int b = 0; b < TL_DW/8; b++) r[8*b +: 8] = {8{m[b]}};
        return r;
    endfunction

endpackage

// File: rtl/tilelink_reg_cell.sv
// tilelink_reg_cell: one 32-bit register, read/write, read-only passthrough or write-1-to-clear
module tilelink_reg_cell
    import tilelink_regfile_pkg::*;
#(
    parameter logic [1:0]  MODE = REG_RW,
    parameter logic [31:0] INIT = 32'h0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic [31:0] wmask,
    input  logic [31:0] hw_set,
    input  logic [31:0] hw_rdata,
    output logic [31:0] q
);

    logic unused_inputs;
    assign unused_inputs = ^{we, wdata, wmask, hw_set, hw_rdata};

    if (MODE == REG_RO) begin : g_ro
        assign q = hw_rdata;
    end else begin : g_store
        logic [31:0] r;
        // W1C: clear written ones, then OR in hardware sets so a same-cycle set wins
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) r <= INIT;
            else if (MODE == REG_W1C) r <= (r & ~(we ? (wdata & wmask) : 32'h0)) | hw_set;
            else if (we) r <= (r & ~wmask) | (wdata & wmask);
        end
        assign q = r;
    end

endmodule

// File: rtl/tilelink_regfile.sv
// tilelink_regfile: TileLink-UL register bank with decode, response register and D handshake
module tilelink_regfile
    import tilelink_regfile_pkg::*;
#(
    parameter int                NREGS     = 4,
    parameter logic [31:0]       ADDR_MASK = 32'hF000_0000,
    parameter logic [31:0]       ADDR_TAG  = 32'hF000_0000,
    parameter logic [31:0]       INIT      = 32'h0,
    parameter logic [NREGS-1:0]  RO_MASK   = '0,
    parameter logic [NREGS-1:0]  W1C_MASK  = '0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  tilelink_a             bus_tla,
    input  logic                  bus_d_ready,
    output tilelink_d             bus_tld,
    input  logic [NREGS*32-1:0]   hw_rdata,
    input  logic [NREGS*32-1:0]   hw_set,
    output logic [NREGS*32-1:0]   reg_q
);

    localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [IW:0] NLIM = NREGS[IW:0];

    typedef enum logic {IDLE, RESP} state_e;

    state_e           state, state_nx;
    logic [IW-1:0]    idx;
    logic             a_ready, accept, bad_idx, is_get, is_put, ro_hit, err, wr;
    logic [31:0]      wmask, rdata;
    tl_d_op_e         rsp_op;
    logic [31:0]      rsp_data;
    logic             rsp_err;
    logic [TL_IW-1:0] rsp_src;
    logic [TL_SW-1:0] rsp_size;
    logic             unused_param;

    assign unused_param = ^bus_tla.a_param;
    assign idx     = (NREGS > 1) ? bus_tla.a_address[2 +: IW] : '0;
    assign bad_idx = {1'b0, idx} >= NLIM;
    assign a_ready = (state == IDLE) || bus_d_ready;
    assign accept  = bus_tla.a_valid && a_ready && ((bus_tla.a_address & ADDR_MASK) == ADDR_TAG);
    assign is_get  = bus_tla.a_opcode == GET;
    assign is_put  = (bus_tla.a_opcode == PUT_FULL_DATA) || (bus_tla.a_opcode == PUT_PARTIAL_DATA);
    assign wmask   = expand_bitmask(bus_tla.a_mask);
    assign err     = bad_idx || !(is_get || is_put) || (is_put && ro_hit);
    assign wr      = accept && is_put && !err;

    // Read mux over the visible register words; also flags read-only targets
    always_comb begin
        rdata  = '0;
        ro_hit = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (idx == IW'(i)) begin
                rdata  = reg_q[32*i +: 32];
                ro_hit = RO_MASK[i];
            end
        end
    end

    for (genvar i = 0; i < NREGS; i++) begin : g_cell
        localparam logic [1:0] KIND = RO_MASK[i] ? REG_RO : (W1C_MASK[i] ? REG_W1C : REG_RW);
        tilelink_reg_cell #(.MODE(KIND), .INIT(INIT)) u_cell (
            .clock    (clock),
            .reset_n  (reset_n),
            .we       (wr && (idx == IW'(i))),
            .wdata    (bus_tla.a_data),
            .wmask    (wmask),
            .hw_set   (hw_set[32*i +: 32]),
            .hw_rdata (hw_rdata[32*i +: 32]),
            .q        (reg_q[32*i +: 32])
        );
    end

    // Handshake state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_nx;
    end

    // Accept always loads a fresh response; otherwise hold until the host takes it
    always_comb begin
        state_nx = accept ? RESP : ((state == RESP && !bus_d_ready) ? RESP : IDLE);
    end

    // Response register captured at accept, held stable under backpressure
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_op   <= ACCESS_ACK;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            rsp_src  <= '0;
            rsp_size <= '0;
        end else if (accept) begin
            rsp_op   <= is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
            rsp_data <= (is_get && !err) ? rdata : '0;
            rsp_err  <= err;
            rsp_src  <= bus_tla.a_source;
            rsp_size <= bus_tla.a_size;
        end
    end

    // D-channel outputs; d_ready reports A-channel readiness
    always_comb begin
        bus_tld.d_valid  = state == RESP;
        bus_tld.d_opcode = rsp_op;
        bus_tld.d_param  = '0;
        bus_tld.d_size   = rsp_size;
        bus_tld.d_source = rsp_src;
        bus_tld.d_sink   = 1'b0;
        bus_tld.d_data   = rsp_data;
        bus_tld.d_error  = rsp_err;
        bus_tld.d_ready  = a_ready;
    end

endmodule

// File: tb/tb_tilelink_regfile.sv
// tb_tilelink_regfile: directed checks of the TileLink register bank
module tb_tilelink_regfile;
    import tilelink_regfile_pkg::*;

    localparam int NREGS = 5;

    logic               clock;
    logic               reset_n;
    tilelink_a          bus_tla;
    logic               bus_d_ready;
    tilelink_d          bus_tld;
    logic [NREGS*32-1:0] hw_rdata;
    logic [NREGS*32-1:0] hw_set;
    logic [NREGS*32-1:0] reg_q;
    int checks;
    int failures;

    tilelink_regfile #(
        .NREGS    (NREGS),
        .ADDR_MASK(32'hF000_0000),
        .ADDR_TAG (32'hF000_0000),
        .INIT     (32'h0),
        .RO_MASK  (5'b01000),
        .W1C_MASK (5'b00100)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .bus_tla    (bus_tla),
        .bus_d_ready(bus_d_ready),
        .bus_tld    (bus_tld),
        .hw_rdata   (hw_rdata),
        .hw_set     (hw_set),
        .reg_q      (reg_q)
    );

    always #5 clock = ~clock;

    task automatic send(input tl_a_op_e op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] mask, input logic [7:0] src);
        bus_tla.a_valid   = 1'b1;
        bus_tla.a_opcode  = op;
        bus_tla.a_address = addr;
        bus_tla.a_data    = data;
        bus_tla.a_mask    = mask;
        bus_tla.a_source  = src;
        bus_tla.a_size    = 3'd2;
        @(negedge clock);
        bus_tla.a_valid   = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checks++; if (bus_tld.d_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", bus_tld.d_valid); end
        checks++; if (bus_tld.d_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0h exp=1", bus_tld.d_ready); end
        checks++; if (bus_tld.d_opcode !== ACCESS_ACK || bus_tld.d_data !== 32'h0 || bus_tld.d_error !== 1'b0 || bus_tld.d_source !== 8'h0)
            begin failures++; $display("FAIL reset_fields got=%0h/%0h/%0h/%0h exp=0/0/0/0", bus_tld.d_opcode, bus_tld.d_data, bus_tld.d_error, bus_tld.d_source); end
        checks++; if (reg_q !== {32'h0, 32'hCAFE0003, 32'h0, 32'h0, 32'h0}) begin failures++; $display("FAIL reset_regq got=%0h", reg_q); end
    endtask

    task automatic test_put_get;
        send(PUT_FULL_DATA, 32'hF000_0004, 32'hDEADBEEF, 4'hF, 8'h05);
        checks++; if (bus_tld.d_valid !== 1'b1 || bus_tld.d_opcode !== ACCESS_ACK) begin failures++; $display("FAIL put_ack got=%0h/%0h exp=1/0", bus_tld.d_valid, bus_tld.d_opcode); end
        checks++; if (bus_tld.d_error !== 1'b0 || bus_tld.d_data !== 32'h0) begin failures++; $display("FAIL put_fields got=%0h/%0h exp=0/0", bus_tld.d_error, bus_tld.d_data); end
        checks++; if (bus_tld.d_source !== 8'h05 || bus_tld.d_size !== 3'd2) begin failures++; $display("FAIL put_echo got=%0h/%0h exp=5/2", bus_tld.d_source, bus_tld.d_size); end
        checks++; if (reg_q[32 +: 32] !== 32'hDEADBEEF) begin failures++; $display("FAIL put_regq got=%0h exp=deadbeef", reg_q[32 +: 32]); end
        send(GET, 32'hF000_0004, 32'h0, 4'hF, 8'h06);
        checks++; if (bus_tld.d_opcode !== ACCESS_ACK_DATA || bus_tld.d_data !== 32'hDEADBEEF) begin failures++; $display("FAIL get_data got=%0h/%0h exp=1/deadbeef", bus_tld.d_opcode, bus_tld.d_data); end
        checks++; if (bus_tld.d_source !== 8'h06) begin failures++; $display("FAIL get_source got=%0h exp=6", bus_tld.d_source); end
        send(GET, 32'hF000_0104, 32'h0, 4'hF, 8'h07);
        checks++; if (bus_tld.d_data !== 32'hDEADBEEF) begin failures++; $display("FAIL get_alias got=%0h exp=deadbeef", bus_tld.d_data); end
        @(negedge clock);
        checks++; if (bus_tld.d_valid !== 1'b0) begin failures++; $display("FAIL drain_valid got=%0h exp=0", bus_tld.d_valid); end
    endtask

    task automatic test_partial;
        send(PUT_FULL_DATA, 32'hF000_0000, 32'hAAAAAAAA, 4'hF, 8'h01);
        send(PUT_PARTIAL_DATA, 32'hF000_0000, 32'h11223344, 4'b0101, 8'h02);
        checks++; if (reg_q[0 +: 32] !== 32'hAA22AA44) begin failures++; $display("FAIL partial_regq got=%0h exp=aa22aa44", reg_q[0 +: 32]); end
        checks++; if (bus_tld.d_error !== 1'b0 || bus_tld.d_opcode !== ACCESS_ACK) begin failures++; $display("FAIL partial_ack got=%0h/%0h exp=0/0", bus_tld.d_error, bus_tld.d_opcode); end
    endtask

    task automatic test_w1c;
        hw_set = '0;
        hw_set[64 +: 32] = 32'h0000000F;
        hw_set[0 +: 32]  = 32'h0000FF00;
        @(negedge clock);
        hw_set = '0;
        checks++; if (reg_q[64 +: 32] !== 32'h0000000F) begin failures++; $display("FAIL w1c_set got=%0h exp=f", reg_q[64 +: 32]); end
        checks++; if (reg_q[0 +: 32] !== 32'hAA22AA44) begin failures++; $display("FAIL rw_ignores_set got=%0h exp=aa22aa44", reg_q[0 +: 32]); end
        hw_set[64 +: 32] = 32'h00000001;
        send(PUT_FULL_DATA, 32'hF000_0008, 32'h00000005, 4'hF, 8'h03);
        hw_set = '0;
        checks++; if (reg_q[64 +: 32] !== 32'h0000000B) begin failures++; $display("FAIL w1c_clear got=%0h exp=b", reg_q[64 +: 32]); end
        checks++; if (bus_tld.d_error !== 1'b0) begin failures++; $display("FAIL w1c_err got=%0h exp=0", bus_tld.d_error); end
        hw_set[64 +: 32] = 32'h00000010;
        send(GET, 32'hF000_0008, 32'h0, 4'hF, 8'h04);
        hw_set = '0;
        checks++; if (bus_tld.d_data !== 32'h0000000B) begin failures++; $display("FAIL w1c_get_preset got=%0h exp=b", bus_tld.d_data); end
        checks++; if (reg_q[64 +: 32] !== 32'h0000001B) begin failures++; $display("FAIL w1c_postset got=%0h exp=1b", reg_q[64 +: 32]); end
        @(negedge clock);
    endtask

    task automatic test_backpressure;
        bus_d_ready = 1'b0;
        send(GET, 32'hF000_0004, 32'h0, 4'hF, 8'h11);
        bus_tla.a_valid   = 1'b1;
        bus_tla.a_opcode  = GET;
        bus_tla.a_address = 32'hF000_0000;
        bus_tla.a_source  = 8'h12;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (bus_tld.d_valid !== 1'b1 || bus_tld.d_data !== 32'hDEADBEEF || bus_tld.d_source !== 8'h11)
                begin failures++; $display("FAIL bp_hold%0d got=%0h/%0h/%0h exp=1/deadbeef/11", k, bus_tld.d_valid, bus_tld.d_data, bus_tld.d_source); end
            checks++; if (bus_tld.d_ready !== 1'b0) begin failures++; $display("FAIL bp_ready%0d got=%0h exp=0", k, bus_tld.d_ready); end
            @(negedge clock);
        end
        bus_d_ready = 1'b1;
        #1;
        checks++; if (bus_tld.d_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%0h exp=1", bus_tld.d_ready); end
        @(negedge clock);
        bus_tla.a_valid = 1'b0;
        checks++; if (bus_tld.d_valid !== 1'b1 || bus_tld.d_data !== 32'hAA22AA44 || bus_tld.d_source !== 8'h12)
            begin failures++; $display("FAIL bp_second got=%0h/%0h/%0h exp=1/aa22aa44/12", bus_tld.d_valid, bus_tld.d_data, bus_tld.d_source); end
        @(negedge clock);
        checks++; if (bus_tld.d_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%0h exp=0", bus_tld.d_valid); end
    endtask

    task automatic test_errors;
        tl_a_op_e op_hint;
        op_hint = HINT;
        send(PUT_FULL_DATA, 32'hF000_000C, 32'h12345678, 4'hF, 8'h21);
        checks++; if (bus_tld.d_error !== 1'b1 || bus_tld.d_opcode !== ACCESS_ACK || bus_tld.d_data !== 32'h0)
            begin failures++; $display("FAIL ro_put got=%0h/%0h/%0h exp=1/0/0", bus_tld.d_error, bus_tld.d_opcode, bus_tld.d_data); end
        send(GET, 32'hF000_000C, 32'h0, 4'hF, 8'h22);
        checks++; if (bus_tld.d_error !== 1'b0 || bus_tld.d_data !== 32'hCAFE0003) begin failures++; $display("FAIL ro_get got=%0h/%0h exp=0/cafe0003", bus_tld.d_error, bus_tld.d_data); end
        send(GET, 32'hF000_0014, 32'h0, 4'hF, 8'h23);
        checks++; if (bus_tld.d_error !== 1'b1 || bus_tld.d_opcode !== ACCESS_ACK_DATA || bus_tld.d_data !== 32'h0)
            begin failures++; $display("FAIL bad_idx_get got=%0h/%0h/%0h exp=1/1/0", bus_tld.d_error, bus_tld.d_opcode, bus_tld.d_data); end
        send(op_hint, 32'hF000_0000, 32'h0, 4'hF, 8'h24);
        checks++; if (bus_tld.d_error !== 1'b1 || bus_tld.d_opcode !== ACCESS_ACK) begin failures++; $display("FAIL hint got=%0h/%0h exp=1/0", bus_tld.d_error, bus_tld.d_opcode); end
        send(PUT_FULL_DATA, 32'hF000_0018, 32'hFFFFFFFF, 4'hF, 8'h25);
        checks++; if (bus_tld.d_error !== 1'b1) begin failures++; $display("FAIL bad_idx_put got=%0h exp=1", bus_tld.d_error); end
        checks++; if (reg_q !== {32'h0, 32'hCAFE0003, 32'h0000001B, 32'hDEADBEEF, 32'hAA22AA44}) begin failures++; $display("FAIL err_nochange got=%0h", reg_q); end
        send(PUT_FULL_DATA, 32'h1000_0000, 32'h0, 4'hF, 8'h26);
        checks++; if (bus_tld.d_valid !== 1'b0) begin failures++; $display("FAIL unselected_valid got=%0h exp=0", bus_tld.d_valid); end
        checks++; if (reg_q[0 +: 32] !== 32'hAA22AA44) begin failures++; $display("FAIL unselected_regq got=%0h exp=aa22aa44", reg_q[0 +: 32]); end
    endtask

    task automatic test_reset_mid_resp;
        bus_d_ready = 1'b0;
        send(GET, 32'hF000_0000, 32'h0, 4'hF, 8'h31);
        checks++; if (bus_tld.d_valid !== 1'b1) begin failures++; $display("FAIL mid_resp_valid got=%0h exp=1", bus_tld.d_valid); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (bus_tld.d_valid !== 1'b0 || bus_tld.d_data !== 32'h0) begin failures++; $display("FAIL mid_reset got=%0h/%0h exp=0/0", bus_tld.d_valid, bus_tld.d_data); end
        checks++; if (reg_q !== {32'h0, 32'hCAFE0003, 32'h0, 32'h0, 32'h0}) begin failures++; $display("FAIL mid_reset_regq got=%0h", reg_q); end
        @(negedge clock);
        reset_n = 1'b1;
        bus_d_ready = 1'b1;
        @(negedge clock);
        checks++; if (bus_tld.d_valid !== 1'b0) begin failures++; $display("FAIL post_reset_valid got=%0h exp=0", bus_tld.d_valid); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        clock = 1'b0;
        reset_n = 1'b0;
        bus_tla = '0;
        bus_d_ready = 1'b1;
        hw_set = '0;
        hw_rdata = {32'hBAD00004, 32'hCAFE0003, 32'hBAD00002, 32'hBAD00001, 32'hBAD00000};
        test_reset();
        test_put_get();
        test_partial();
        test_w1c();
        test_backpressure();
        test_errors();
        test_reset_mid_resp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
